mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_rr2.sv | 21 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D main-memory arbiter: FSM states, grant ids,
// parameter defaults and the latched request record.
package mem_arb_pkg;

  localparam int MM_LATENCY_DEF = 4;
  localparam int CNT_W_DEF      = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mm_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick, purely combinational; on a tie the side that
// was not granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic gnt
);

  always_comb begin
    gnt = GNT_I;
    if (req_i && req_d) begin
      gnt = ~last;
    end else if (req_d) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency main memory between an I-cache refill port and a
// data port: IDLE -> BUSY (MM_LATENCY cycles) -> RESP (one Ready pulse).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MM_LATENCY = MM_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_Req,
  input  logic [31:0]      I_Addr,
  output logic             I_Ready,
  output logic [31:0]      I_Data,
  input  logic             D_Req,
  input  logic             D_We,
  input  logic [31:0]      D_Addr,
  input  logic [31:0]      D_Wdata,
  output logic             D_Ready,
  output logic [31:0]      D_Rdata,
  output logic             MM_Access,
  output logic             MM_We,
  output logic [31:0]      MM_Addr,
  output logic [31:0]      MM_Wdata,
  input  logic [31:0]      MM_Rdata,
  output logic             Busy,
  output logic [CNT_W-1:0] CNT_I,
  output logic [CNT_W-1:0] CNT_D
);

  localparam logic [3:0] LAT_LOAD = 4'(MM_LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic             gnt_q, last_q, gnt;
  mm_req_t          req_q;
  logic [31:0]      i_data_q, d_rdata_q;
  logic [CNT_W-1:0] cnt_i_q, cnt_d_q;
  logic             any_req;

  assign any_req = I_Req || D_Req;

  arb_rr2 u_arb (
    .req_i (I_Req),
    .req_d (D_Req),
    .last  (last_q),
    .gnt   (gnt)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          lat_d   = LAT_LOAD;
        end
      end
      ST_BUSY: begin
        if (lat_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      lat_q     <= 4'd0;
      gnt_q     <= GNT_I;
      last_q    <= GNT_I;
      req_q     <= '0;
      i_data_q  <= 32'd0;
      d_rdata_q <= 32'd0;
      cnt_i_q   <= '0;
      cnt_d_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      // Request fields are captured only here, so later input changes are ignored.
      if (state_q == ST_IDLE && any_req) begin
        gnt_q  <= gnt;
        last_q <= gnt;
        if (gnt == GNT_D) begin
          req_q <= '{we: D_We, addr: D_Addr & WORD_MASK, wdata: D_Wdata};
        end else begin
          req_q <= '{we: 1'b0, addr: I_Addr & WORD_MASK, wdata: 32'd0};
        end
      end
      if (state_q == ST_BUSY && lat_q == 4'd0 && !req_q.we) begin
        if (gnt_q == GNT_D) begin
          d_rdata_q <= MM_Rdata;
        end else begin
          i_data_q <= MM_Rdata;
        end
      end
      if (state_q == ST_RESP) begin
        if (gnt_q == GNT_D) begin
          if (cnt_d_q != '1) cnt_d_q <= cnt_d_q + CNT_W'(1);
        end else begin
          if (cnt_i_q != '1) cnt_i_q <= cnt_i_q + CNT_W'(1);
        end
      end
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign MM_Access = (state_q == ST_BUSY);
  assign MM_We     = MM_Access && req_q.we;
  assign MM_Addr   = req_q.addr;
  assign MM_Wdata  = req_q.wdata;
  assign I_Ready   = (state_q == ST_RESP) && (gnt_q == GNT_I);
  assign D_Ready   = (state_q == ST_RESP) && (gnt_q == GNT_D);
  assign I_Data    = i_data_q;
  assign D_Rdata   = d_rdata_q;
  assign CNT_I     = cnt_i_q;
  assign CNT_D     = cnt_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance plus a MM_LATENCY=1,
// CNT_W=3 instance used for the short-latency and counter-saturation cases.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET;
  logic        I_Req, I_Ready, D_Req, D_We, D_Ready, MM_Access, MM_We, Busy;
  logic [31:0] I_Addr, I_Data, D_Addr, D_Wdata, D_Rdata, MM_Addr, MM_Wdata, MM_Rdata;
  logic [19:0] CNT_I, CNT_D;

  logic        s_I_Req, s_I_Ready, s_D_Req, s_D_We, s_D_Ready, s_MM_Access, s_MM_We, s_Busy;
  logic [31:0] s_I_Addr, s_I_Data, s_D_Addr, s_D_Wdata, s_D_Rdata, s_MM_Addr, s_MM_Wdata, s_MM_Rdata;
  logic [2:0]  s_CNT_I, s_CNT_D;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Ready(I_Ready), .I_Data(I_Data),
    .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_Wdata(D_Wdata),
    .D_Ready(D_Ready), .D_Rdata(D_Rdata),
    .MM_Access(MM_Access), .MM_We(MM_We), .MM_Addr(MM_Addr), .MM_Wdata(MM_Wdata),
    .MM_Rdata(MM_Rdata), .Busy(Busy), .CNT_I(CNT_I), .CNT_D(CNT_D)
  );

  mem_arbiter #(.MM_LATENCY(1), .CNT_W(3)) dut_s (
    .CLK(CLK), .RESET(RESET),
    .I_Req(s_I_Req), .I_Addr(s_I_Addr), .I_Ready(s_I_Ready), .I_Data(s_I_Data),
    .D_Req(s_D_Req), .D_We(s_D_We), .D_Addr(s_D_Addr), .D_Wdata(s_D_Wdata),
    .D_Ready(s_D_Ready), .D_Rdata(s_D_Rdata),
    .MM_Access(s_MM_Access), .MM_We(s_MM_We), .MM_Addr(s_MM_Addr), .MM_Wdata(s_MM_Wdata),
    .MM_Rdata(s_MM_Rdata), .Busy(s_Busy), .CNT_I(s_CNT_I), .CNT_D(s_CNT_D)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  // One cycle of a main-instance transaction whose access window starts at a0.
  task automatic txn_cycle(input string tag, input int c, input int a0, input logic dside,
                           input logic we, input logic [31:0] addr);
    logic acc;
    logic rdy;
    acc = (c >= a0) && (c < a0 + 4);
    rdy = (c == a0 + 4);
    @(negedge CLK);
    chk({tag, "_acc"},  32'(MM_Access), 32'(acc));
    chk({tag, "_we"},   32'(MM_We),     32'(acc && we));
    if (acc) chk({tag, "_addr"}, MM_Addr, addr);
    chk({tag, "_irdy"}, 32'(I_Ready),   32'(rdy && !dside));
    chk({tag, "_drdy"}, 32'(D_Ready),   32'(rdy && dside));
    chk({tag, "_busy"}, 32'(Busy),      32'(acc || rdy));
  endtask

  initial begin
    int k;
    int last_c;
    int found;
    RESET = 1'b1;
    I_Req = 0; I_Addr = 0; D_Req = 0; D_We = 0; D_Addr = 0; D_Wdata = 0; MM_Rdata = 0;
    s_I_Req = 0; s_I_Addr = 0; s_D_Req = 0; s_D_We = 0; s_D_Addr = 0; s_D_Wdata = 0; s_MM_Rdata = 0;
    repeat (2) nxt;
    RESET = 1'b0;

    @(negedge CLK);
    chk("rst_acc",   32'(MM_Access), 32'd0);
    chk("rst_we",    32'(MM_We),     32'd0);
    chk("rst_addr",  MM_Addr,        32'd0);
    chk("rst_wdata", MM_Wdata,       32'd0);
    chk("rst_idata", I_Data,         32'd0);
    chk("rst_drdata", D_Rdata,       32'd0);
    chk("rst_busy",  32'(Busy),      32'd0);
    chk("rst_cnt",   32'(CNT_I) + 32'(CNT_D), 32'd0);
    chk("rst_rdy",   32'({I_Ready, D_Ready}), 32'd0);
    nxt;

    // Lone I refill, byte address 0x13 maps to word 0x10.
    I_Req = 1; I_Addr = 32'h0000_0013; MM_Rdata = 32'h2008_0005;
    for (int c = 0; c <= 5; c++) begin
      txn_cycle("i1", c, 1, 1'b0, 1'b0, 32'h10);
      if (c == 5) chk("i1_data", I_Data, 32'h2008_0005);
      nxt;
    end
    I_Req = 0;
    @(negedge CLK);
    chk("i1_cnt",  32'(CNT_I), 32'd1);
    chk("i1_idle", 32'(Busy),  32'd0);
    nxt;

    // Tie after an I grant: D first, then I; D_Addr change mid-BUSY ignored.
    I_Req = 1; I_Addr = 32'h100; D_Req = 1; D_We = 0; D_Addr = 32'h84; MM_Rdata = 32'hAAAA_5555;
    for (int c = 0; c <= 11; c++) begin
      if (c == 2) D_Addr = 32'hFFC;
      if (c == 6) MM_Rdata = 32'h5555_AAAA;
      if (c <= 5) txn_cycle("tie_d", c, 1, 1'b1, 1'b0, 32'h84);
      else        txn_cycle("tie_i", c, 7, 1'b0, 1'b0, 32'h100);
      if (c == 5)  chk("tie_drdata", D_Rdata, 32'hAAAA_5555);
      if (c == 11) chk("tie_idata",  I_Data,  32'h5555_AAAA);
      if (c == 11) chk("tie_dhold",  D_Rdata, 32'hAAAA_5555);
      nxt;
      if (c == 5)  D_Req = 0;
      if (c == 11) I_Req = 0;
    end

    // Continuous requests from both sides: strict alternation starting with D.
    I_Req = 1; D_Req = 1; D_Addr = 32'h84; k = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      @(negedge CLK);
      if (I_Ready || D_Ready) begin
        chk("rr_gnt", 32'(D_Ready), 32'((k % 2) == 0));
        chk("rr_one", 32'(I_Ready ^ D_Ready), 32'd1);
        k++;
      end
      nxt;
    end
    chk("rr_count", 32'(k), 32'd6);
    I_Req = 0; D_Req = 0;
    @(negedge CLK);
    chk("rr_cnti", 32'(CNT_I), 32'd5);
    chk("rr_cntd", 32'(CNT_D), 32'd4);
    nxt;

    // D read then D write; the write must leave D_Rdata untouched.
    D_Req = 1; D_We = 0; D_Addr = 32'h44; MM_Rdata = 32'h1234_5678;
    for (int c = 0; c <= 5; c++) begin
      txn_cycle("dr", c, 1, 1'b1, 1'b0, 32'h44);
      if (c == 5) chk("dr_data", D_Rdata, 32'h1234_5678);
      nxt;
    end
    D_Req = 1; D_We = 1; D_Addr = 32'h40; D_Wdata = 32'hDEAD_BEEF; MM_Rdata = 32'hBAD0_BAD0;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) D_Wdata = 32'h0;
      txn_cycle("dw", c, 1, 1'b1, 1'b1, 32'h40);
      if (c >= 1 && c <= 4) chk("dw_wdata", MM_Wdata, 32'hDEAD_BEEF);
      if (c == 5) chk("dw_hold", D_Rdata, 32'h1234_5678);
      nxt;
    end
    D_Req = 0; D_We = 0;
    @(negedge CLK);
    chk("dw_cntd", 32'(CNT_D), 32'd6);
    nxt;

    // Reset during cycle 2 of a D read abandons it.
    D_Req = 1; D_Addr = 32'h200; MM_Rdata = 32'h0F0F_0F0F;
    nxt;
    @(negedge CLK);
    chk("rs_acc1", 32'(MM_Access), 32'd1);
    nxt;
    RESET = 1; D_Req = 0;
    @(negedge CLK);
    chk("rs_acc2", 32'(MM_Access), 32'd1);
    nxt;
    RESET = 0;
    @(negedge CLK);
    chk("rs_acc3",  32'(MM_Access), 32'd0);
    chk("rs_busy",  32'(Busy),      32'd0);
    chk("rs_cnti",  32'(CNT_I),     32'd0);
    chk("rs_cntd",  32'(CNT_D),     32'd0);
    chk("rs_rdata", D_Rdata,        32'd0);
    nxt;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (D_Ready || I_Ready) found++;
      nxt;
    end
    chk("rs_noready", 32'(found), 32'd0);
    I_Req = 1; I_Addr = 32'h300; D_Req = 1; D_Addr = 32'h400; found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      @(negedge CLK);
      if (I_Ready || D_Ready) begin
        found = 1;
        chk("rs_tie_d",   32'(D_Ready), 32'd1);
        chk("rs_tie_lat", 32'(c),       32'd5);
      end
      nxt;
    end
    chk("rs_tie_seen", 32'(found), 32'd1);
    I_Req = 0; D_Req = 0;
    nxt;

    // MM_LATENCY=1 instance: one BUSY cycle, then saturate a 3-bit counter.
    s_I_Req = 1; s_I_Addr = 32'h0000_000B; s_MM_Rdata = 32'h77;
    for (int c = 0; c <= 2; c++) begin
      @(negedge CLK);
      chk("s_acc",  32'(s_MM_Access), 32'(c == 1));
      chk("s_rdy",  32'(s_I_Ready),   32'(c == 2));
      if (c == 1) chk("s_addr", s_MM_Addr, 32'h8);
      if (c == 2) chk("s_data", s_I_Data,  32'h77);
      nxt;
    end
    k = 1; last_c = 2;
    for (int c = 3; c < 60 && k < 9; c++) begin
      @(negedge CLK);
      if (s_I_Ready) begin
        k++;
        chk("s_period", 32'(c - last_c), 32'd3);
        last_c = c;
        if (k == 8) chk("s_cnt7", 32'(s_CNT_I), 32'd7);
      end
      nxt;
    end
    chk("s_count", 32'(k), 32'd9);
    s_I_Req = 0;
    @(negedge CLK);
    chk("s_sat", 32'(s_CNT_I), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
